// File: rtl/arp_pkg.sv
// Shared ARP constants, header struct and byte-ordering helper for the ARP TX path.
// Build option: ARP_ETH_TX_PAD_EN pads the payload to the Ethernet minimum length.
package arp_pkg;

  localparam int unsigned ARP_HDR_LEN      = 28;
  localparam int unsigned ETH_MIN_PAYLOAD  = 46;
  localparam logic [7:0]  ARP_HLEN         = 8'd6;
  localparam logic [7:0]  ARP_PLEN         = 8'd4;
  localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'd1;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'd2;

`ifdef ARP_ETH_TX_PAD_EN
  localparam int unsigned ARP_TX_PKT_LEN = ETH_MIN_PAYLOAD;
`else
  localparam int unsigned ARP_TX_PKT_LEN = ARP_HDR_LEN;
`endif

  typedef struct packed {
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_hdr_t;

  // Returns the ARP packet with wire byte i at bits [i*8 +: 8].
  function automatic logic [ARP_HDR_LEN*8-1:0] arp_pack_bytes(input arp_hdr_t h);
    logic [ARP_HDR_LEN*8-1:0] msb_first;
    logic [ARP_HDR_LEN*8-1:0] res;
    msb_first = {h.htype, h.ptype, ARP_HLEN, ARP_PLEN, h.oper, h.sha, h.spa, h.tha, h.tpa};
    res = '0;
    for (int i = 0; i < int'(ARP_HDR_LEN); i++) begin
      res[i*8 +: 8] = msb_first[(int'(ARP_HDR_LEN) - 1 - i)*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/arp_eth_tx_beat_mux.sv
// Combinational selection of one payload beat (data, byte enables, last flag) from ARP fields.
// Under ARP_ETH_TX_PAD_EN the beat count covers the zero-padded 46-byte payload.
module arp_eth_tx_beat_mux
  import arp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KEEP_WIDTH  = 1,
  parameter int unsigned CYCLE_COUNT = 28,
  parameter int unsigned PTR_WIDTH   = 5
) (
  input  arp_hdr_t              hdr,
  input  logic [PTR_WIDTH-1:0]  beat,
  output logic [DATA_WIDTH-1:0] tdata_c,
  output logic [KEEP_WIDTH-1:0] tkeep_c,
  output logic                  tlast_c
);

  localparam int unsigned VEC_W    = CYCLE_COUNT * DATA_WIDTH;
  localparam int unsigned LAST_REM = ARP_TX_PKT_LEN % KEEP_WIDTH;
  localparam logic [KEEP_WIDTH-1:0] KEEP_ALL  = '1;
  localparam logic [KEEP_WIDTH-1:0] LAST_KEEP =
    (LAST_REM == 0) ? KEEP_ALL : (KEEP_ALL >> (KEEP_WIDTH - LAST_REM));

  logic [VEC_W-1:0] pkt_vec;

  // Pad bytes and unused lanes of the final beat read as zero.
  always_comb begin
    pkt_vec = '0;
    pkt_vec[ARP_HDR_LEN*8-1:0] = arp_pack_bytes(hdr);
  end

  assign tdata_c = pkt_vec[int'(beat)*DATA_WIDTH +: DATA_WIDTH];
  assign tlast_c = (beat == PTR_WIDTH'(CYCLE_COUNT - 1));
  assign tkeep_c = tlast_c ? LAST_KEEP : KEEP_ALL;

endmodule

// File: rtl/arp_eth_tx.sv
// ARP frame transmitter: parallel ARP frame in, Ethernet header + serialized AXI-stream payload out.
// Build option: ARP_ETH_TX_PAD_EN (zero-pads the payload to 46 bytes).
module arp_eth_tx
  import arp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH  = (DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_frame_valid,
  output logic                  s_frame_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [15:0]           s_arp_htype,
  input  logic [15:0]           s_arp_ptype,
  input  logic [15:0]           s_arp_oper,
  input  logic [47:0]           s_arp_sha,
  input  logic [31:0]           s_arp_spa,
  input  logic [47:0]           s_arp_tha,
  input  logic [31:0]           s_arp_tpa,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  output logic                  busy
);

  localparam int unsigned CYCLE_COUNT = (ARP_TX_PKT_LEN + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int unsigned PTR_W       = (CYCLE_COUNT > 1) ? $clog2(CYCLE_COUNT) : 1;
  localparam logic [0:0]  ST_IDLE     = 1'b0;
  localparam logic [0:0]  ST_SEND     = 1'b1;

  if (DATA_WIDTH != KEEP_WIDTH * 8) begin : g_width_err
    $error("arp_eth_tx: DATA_WIDTH must equal KEEP_WIDTH*8");
  end

  logic [0:0]            state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  arp_hdr_t              hdr_q, hdr_d, hdr_in, mux_hdr;
  logic [47:0]           dest_q, dest_d, src_q, src_d;
  logic [15:0]           type_q, type_d;
  logic                  hvalid_q, hvalid_d, tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic                  busy_q, busy_d, fready_q, fready_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d, beat_tdata;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d, beat_tkeep;
  logic                  beat_tlast, accept;
  logic [PTR_W-1:0]      mux_beat;

  assign accept = (state_q == ST_IDLE) && s_frame_valid && fready_q;

  always_comb begin
    hdr_in.htype = s_arp_htype;
    hdr_in.ptype = s_arp_ptype;
    hdr_in.oper  = s_arp_oper;
    hdr_in.sha   = s_arp_sha;
    hdr_in.spa   = s_arp_spa;
    hdr_in.tha   = s_arp_tha;
    hdr_in.tpa   = s_arp_tpa;
  end

  // On accept the first beat is built straight from the inputs being latched.
  assign mux_hdr  = accept ? hdr_in : hdr_q;
  assign mux_beat = accept ? '0 : ptr_q + PTR_W'(1);

  arp_eth_tx_beat_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .CYCLE_COUNT(CYCLE_COUNT),
    .PTR_WIDTH  (PTR_W)
  ) u_beat_mux (
    .hdr    (mux_hdr),
    .beat   (mux_beat),
    .tdata_c(beat_tdata),
    .tkeep_c(beat_tkeep),
    .tlast_c(beat_tlast)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      hdr_q    <= '0;
      dest_q   <= '0;
      src_q    <= '0;
      type_q   <= '0;
      hvalid_q <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      busy_q   <= 1'b0;
      fready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hdr_q    <= hdr_d;
      dest_q   <= dest_d;
      src_q    <= src_d;
      type_q   <= type_d;
      hvalid_q <= hvalid_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      busy_q   <= busy_d;
      fready_q <= fready_d;
    end
  end

  // Next-state: header and payload channels retire independently; IDLE once both are done.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hdr_d    = hdr_q;
    dest_d   = dest_q;
    src_d    = src_q;
    type_d   = type_q;
    hvalid_d = hvalid_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    busy_d   = busy_q;
    fready_d = fready_q;
    case (state_q)
      ST_IDLE: begin
        fready_d = 1'b1;
        if (accept) begin
          hdr_d    = hdr_in;
          dest_d   = s_eth_dest_mac;
          src_d    = s_eth_src_mac;
          type_d   = s_eth_type;
          hvalid_d = 1'b1;
          tvalid_d = 1'b1;
          tdata_d  = beat_tdata;
          tkeep_d  = beat_tkeep;
          tlast_d  = beat_tlast;
          ptr_d    = '0;
          busy_d   = 1'b1;
          fready_d = 1'b0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        fready_d = 1'b0;
        if (hvalid_q && m_eth_hdr_ready) begin
          hvalid_d = 1'b0;
        end
        if (tvalid_q && m_eth_payload_axis_tready) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
            tkeep_d  = '0;
            busy_d   = 1'b0;
          end else begin
            ptr_d    = mux_beat;
            tdata_d  = beat_tdata;
            tkeep_d  = beat_tkeep;
            tlast_d  = beat_tlast;
          end
        end
        if (!hvalid_d && !tvalid_d) begin
          ptr_d    = '0;
          fready_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_frame_ready             = fready_q;
  assign m_eth_hdr_valid           = hvalid_q;
  assign m_eth_dest_mac            = dest_q;
  assign m_eth_src_mac             = src_q;
  assign m_eth_type                = type_q;
  assign m_eth_payload_axis_tdata  = tdata_q;
  assign m_eth_payload_axis_tkeep  = KEEP_ENABLE ? tkeep_q : '1;
  assign m_eth_payload_axis_tvalid = tvalid_q;
  assign m_eth_payload_axis_tlast  = tlast_q;
  assign m_eth_payload_axis_tuser  = 1'b0;
  assign busy                      = busy_q;

endmodule

// File: doc/arp_eth_tx.md
Name: arp_eth_tx

Overview:
- ARP frame transmitter: takes a parallel ARP frame (Ethernet header fields plus ARP fields) and emits an Ethernet frame.
- Ethernet header fields go out in parallel on a valid/ready header channel.
- The 28-byte ARP packet goes out serialized on an AXI-stream payload channel.
- Sits between the ARP cache/responder logic and the Ethernet TX mux.

Parameters:
- DATA_WIDTH, 8, payload tdata width in bits; must equal KEEP_WIDTH*8, otherwise elaboration error.
- KEEP_ENABLE, (DATA_WIDTH>8), drive tkeep; when 0, tkeep is tied to all-ones.
- KEEP_WIDTH, (DATA_WIDTH/8), tkeep width in bytes per beat.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- s_frame_valid  in  1  input ARP frame valid.
- s_frame_ready  out  1  input ARP frame accepted.
- s_eth_dest_mac / s_eth_src_mac  in  48  Ethernet MACs.
- s_eth_type  in  16  Ethertype; passed through unmodified.
- s_arp_htype / s_arp_ptype / s_arp_oper  in  16  ARP fields.
- s_arp_sha / s_arp_tha  in  48  sender / target MAC.
- s_arp_spa / s_arp_tpa  in  32  sender / target IP.
- m_eth_hdr_valid  out  1  header valid.
- m_eth_hdr_ready  in  1  header accepted.
- m_eth_dest_mac / m_eth_src_mac  out  48  registered MACs.
- m_eth_type  out  16  registered Ethertype.
- m_eth_payload_axis_tdata  out  DATA_WIDTH  payload data.
- m_eth_payload_axis_tkeep  out  KEEP_WIDTH  byte enables.
- m_eth_payload_axis_tvalid / tlast / tuser  out  1  stream controls; tuser is always 0.
- m_eth_payload_axis_tready  in  1  downstream ready.
- busy  out  1  high from frame accept until the tlast beat transfers.

Behaviour:
- Packet byte order: htype[15:8], htype[7:0], ptype hi, ptype lo, hlen=8'd6, plen=8'd4, oper hi, oper lo, sha[47:40]..sha[7:0], spa[31:24]..[7:0], tha MSB-first, tpa MSB-first.
  - Total 28 bytes; hlen and plen are constants, not ports.
- Byte i maps to beat i/KEEP_WIDTH, lane i%KEEP_WIDTH (bits (i%KW)*8 +: 8).
- CYCLE_COUNT = ceil(28/KEEP_WIDTH) beats.
- Final beat: tlast=1; tkeep low (28%KW) bits set, or all ones if 28%KW==0.
- Non-final beats: tkeep all ones. Unused lanes of the final beat drive 0.
- States:
  - IDLE: s_frame_ready=1. On s_frame_valid&&s_frame_ready: latch all inputs, set m_eth_hdr_valid=1 and the first payload beat tvalid=1 on the next cycle, go to SEND, busy=1.
  - SEND: s_frame_ready=0.
    - Header: m_eth_hdr_valid holds with stable fields until m_eth_hdr_ready, then drops.
    - Payload: each beat holds stable until tready; the beat pointer increments on transfer.
    - Header and payload channels are independent; payload may complete before the header and vice versa.
    - When both the header has transferred and the tlast beat has transferred, go to IDLE.
    - busy drops the cycle after the tlast transfer.
    - s_frame_ready rises the cycle after both complete, so back-to-back frames have 1 idle cycle minimum.
- Frame latency: accept at cycle N -> header valid and first beat valid at N+1. With tready held high, tlast transfers at N+CYCLE_COUNT.
- Pointer width: $clog2(CYCLE_COUNT), minimum 1. Pointer clears to 0 on return to IDLE; no wrap inside a frame.
- Reset (rst_n=0 at a clk edge):
  - s_frame_ready=0 during reset, 1 the cycle after release.
  - m_eth_hdr_valid=0, tvalid=0, tlast=0, tuser=0, tkeep=0, tdata=0, busy=0, state=IDLE, pointer=0.
  - Latched MACs/fields reset to 0.
  - Reset mid-frame aborts immediately. No partial frame is resumed; the downstream sees tvalid drop without tlast.
- Input fields are sampled only on the accept cycle; later changes are ignored.

Optional Feature:
- Macro: ARP_ETH_TX_PAD_EN.
- Defined: payload zero-padded to the 46-byte Ethernet minimum.
  - Bytes 28..45 are 0.
  - CYCLE_COUNT = ceil(46/KEEP_WIDTH); tlast and the partial tkeep are computed from 46.
- Undefined: 28-byte payload as above. Padding is left to the MAC.

Decomposition:
- Package arp_pkg:
  - ARP_HDR_LEN=28, ETH_MIN_PAYLOAD=46.
  - ARP_HLEN=8'd6, ARP_PLEN=8'd4, ETHERTYPE_ARP=16'h0806, ARP_OPER_REQUEST=1, ARP_OPER_REPLY=2.
  - Packed struct arp_hdr_t of the ARP fields.
- Sub-module: none required.
- Optional sub-module: arp_eth_tx_beat_mux, a combinational mux from latched fields plus pointer to tdata/tkeep/tlast. It keeps the FSM file small.

Test Plan:
1. DATA_WIDTH=8, htype=1, ptype=0x0800, oper=1, sha=02:00:00:00:00:01, spa=C0A80001, tha=0, tpa=C0A80002, tready=1 -> 28 beats with bytes 00 01 08 00 06 04 00 01 02 00 00 00 00 01 C0 A8 00 01 00×6 C0 A8 00 02, tlast on beat 27, header fields match.
2. DATA_WIDTH=64, same frame -> 4 beats; beat 3 tkeep=8'h0F, tdata[31:0]=02 00 A8 C0 in lane order (lane0=0xC0), tlast=1.
3. Random tready (50%) and m_eth_hdr_ready delayed 40 cycles -> payload is stable across stalls, s_frame_ready stays 0 until the header transfers, busy drops after tlast.
4. Two back-to-back frames with s_frame_valid held -> second accepted exactly 1 cycle after the first completes; no field bleed-through.
5. rst_n=0 at beat 10 of 28 -> next cycle all valids 0 and busy=0. After release, a new frame emits a full 28 beats from byte 0.
6. ARP_ETH_TX_PAD_EN defined, DATA_WIDTH=8 -> 46 beats, bytes 28..45 all 0, tlast on beat 45.
